// File: rtl/jtframe_pocket_dwnld_if.sv
// Bridge-side write port and ioctl-side programmer port of the Pocket download engine.
interface jtframe_pocket_dwnld_if #(
  parameter int OW  = 8,
  parameter int AW  = 25,
  parameter int FAW = 3
);
  logic          wr_s;
  logic [31:0]   data_s;
  logic [31:0]   addr_s;
  logic          slot_done;
  logic          prog_rdy;
  logic [AW-1:0] ioctl_addr;
  logic [OW-1:0] ioctl_dout;
  logic          ioctl_wr;
  logic          downloading;
  logic          ovf;
  logic [FAW:0]  fifo_lvl;

  modport master (
    output wr_s, data_s, addr_s, slot_done, prog_rdy,
    input  ioctl_addr, ioctl_dout, ioctl_wr, downloading, ovf, fifo_lvl
  );

  modport slave (
    input  wr_s, data_s, addr_s, slot_done, prog_rdy,
    output ioctl_addr, ioctl_dout, ioctl_wr, downloading, ovf, fifo_lvl
  );
endinterface

// File: rtl/jtframe_pocket_dwnld.sv
// Pocket bridge-to-ioctl download engine: queues 32-bit bridge words and
// serialises them into OW-bit ioctl writes paced by prog_rdy.
module jtframe_pocket_dwnld #(
  parameter int OW     = 8,
  parameter int AW     = 25,
  parameter int FAW    = 3,
  parameter int BIGEND = 1
) (
  input  logic                    clk_rom,
  input  logic                    rst,
  jtframe_pocket_dwnld_if.slave   dl
);

  localparam int DEPTH = 1 << FAW;
  localparam int EW    = AW - 2 + 32;
  localparam int NU    = 32 / OW;
  localparam int STEP  = OW / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  logic [EW-1:0]  mem_r [DEPTH];
  logic [FAW-1:0] wr_ptr_r, rd_ptr_r;
  logic [FAW:0]   lvl_r;
  logic           full_s, empty_s, push_s, pop_s, step_s, done_clr_s;
  logic [EW-1:0]  head_s;
  logic [31:0]    shift_r, shifted_s;
  logic [1:0]     cnt_r;
  state_t         state_r, state_nxt_s;
  logic           done_pend_r, dl_r, ovf_r, wr_r;
  logic [AW-1:0]  addr_r;
  logic [OW-1:0]  dout_r;
  logic           unused_s;

  // Unit k of ioctl_dout holds the byte at the k-th address of the unit.
  function automatic logic [OW-1:0] unit_of(input logic [31:0] v);
    logic [OW-1:0] u;
    u = '0;
    for (int k = 0; k < OW / 8; k++) begin
      if (BIGEND != 0) u[8*k +: 8] = v[31-8*k -: 8];
      else             u[8*k +: 8] = v[8*k +: 8];
    end
    return u;
  endfunction

  assign full_s     = lvl_r[FAW];
  assign empty_s    = (lvl_r == '0);
  assign push_s     = dl.wr_s & ~full_s;
  assign head_s     = mem_r[rd_ptr_r];
  assign done_clr_s = done_pend_r & empty_s & (state_r == ST_IDLE);
  assign unused_s   = ^{dl.addr_s[31:AW], dl.addr_s[1:0]};

  // Next-state decode; prog_rdy only matters while waiting on the programmer.
  always_comb begin
    state_nxt_s = state_r;
    pop_s       = 1'b0;
    step_s      = 1'b0;
    shifted_s   = shift_r;
    if (BIGEND != 0) shifted_s = shift_r << OW;
    else             shifted_s = shift_r >> OW;
    case (state_r)
      ST_IDLE: begin
        if (!empty_s) begin
          pop_s       = 1'b1;
          state_nxt_s = ST_EMIT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_EMIT: state_nxt_s = ST_WAIT;
      ST_WAIT: begin
        if (dl.prog_rdy) begin
          if (cnt_r != 2'd0) begin
            step_s      = 1'b1;
            state_nxt_s = ST_EMIT;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_rom or posedge rst) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_nxt_s;
  end

  // FIFO storage; contents are don't-care until the pointers say otherwise.
  always_ff @(posedge clk_rom) begin
    if (push_s) mem_r[wr_ptr_r] <= {dl.addr_s[AW-1:2], dl.data_s};
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk_rom or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      lvl_r    <= '0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + FAW'(1'b1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + FAW'(1'b1);
      case ({push_s, pop_s})
        2'b10:   lvl_r <= lvl_r + (FAW+1)'(1'b1);
        2'b01:   lvl_r <= lvl_r - (FAW+1)'(1'b1);
        default: lvl_r <= lvl_r;
      endcase
    end
  end

  // Serialiser datapath: load on pop, shift one unit per accepted write.
  always_ff @(posedge clk_rom or posedge rst) begin
    if (rst) begin
      shift_r <= 32'd0;
      cnt_r   <= 2'd0;
      addr_r  <= '0;
      dout_r  <= '0;
      wr_r    <= 1'b0;
    end else begin
      wr_r <= (state_nxt_s == ST_EMIT);
      if (pop_s) begin
        shift_r <= head_s[31:0];
        dout_r  <= unit_of(head_s[31:0]);
        addr_r  <= {head_s[EW-1:32], 2'b00};
        cnt_r   <= 2'(NU - 1);
      end else if (step_s) begin
        shift_r <= shifted_s;
        dout_r  <= unit_of(shifted_s);
        addr_r  <= addr_r + AW'(STEP);
        cnt_r   <= cnt_r - 2'd1;
      end
    end
  end

  // Download window and sticky overflow; a new window clears a stale ovf.
  always_ff @(posedge clk_rom or posedge rst) begin
    if (rst) begin
      dl_r        <= 1'b0;
      done_pend_r <= 1'b0;
      ovf_r       <= 1'b0;
    end else begin
      if (push_s)          dl_r <= 1'b1;
      else if (done_clr_s) dl_r <= 1'b0;
      if (done_clr_s)                  done_pend_r <= 1'b0;
      else if (dl.slot_done && dl_r)   done_pend_r <= 1'b1;
      if (dl.wr_s && full_s)           ovf_r <= 1'b1;
      else if (push_s && !dl_r)        ovf_r <= 1'b0;
    end
  end

  assign dl.ioctl_addr  = addr_r;
  assign dl.ioctl_dout  = dout_r;
  assign dl.ioctl_wr    = wr_r;
  assign dl.downloading = dl_r;
  assign dl.ovf         = ovf_r;
  assign dl.fifo_lvl    = lvl_r;

endmodule
